// File: rtl/led_packet_parser.sv
// Framed UART command parser: decodes SYNC/ADDR/COUNT/GRB.../CHECK packets
// and issues one 24-bit colour write per LED to the LED memory write port.
module led_packet_parser #(
  parameter int         ADDRESS_WIDTH  = 9,
  parameter int         TIMEOUT_CYCLES = 120000,
  parameter logic [7:0] SYNC_BYTE      = 8'hAA
) (
  input  logic                     clock_12mhz,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_data_ready,
  output logic                     perform_write,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [23:0]              write_data,
  output logic                     frame_done,
  output logic                     checksum_error,
  output logic                     timeout_error,
  output logic                     busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_ADDR_LO = 3'd2;
  localparam logic [2:0] ST_COUNT   = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_CHECK   = 3'd5;

  localparam int              TW           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                     rdy_meta_q, rdy_sync_q, rdy_prev_q;
  logic                     byte_accept;

  logic [2:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               led_cnt_q, led_cnt_d;
  logic [1:0]               byte_idx_q, byte_idx_d;
  logic [7:0]               g_q, g_d, r_q, r_d;
  logic [7:0]               acc_q, acc_d;
  logic [TW-1:0]            to_cnt_q, to_cnt_d;
  logic                     wr_q, wr_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]              wr_data_q, wr_data_d;
  logic                     done_q, done_d, cerr_q, cerr_d, terr_q, terr_d;

  // Stages reset high so a level already asserted during reset never looks like a new rising edge.
  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      rdy_meta_q <= 1'b1;
      rdy_sync_q <= 1'b1;
      rdy_prev_q <= 1'b1;
    end else begin
      rdy_meta_q <= rx_data_ready;
      rdy_sync_q <= rdy_meta_q;
      rdy_prev_q <= rdy_sync_q;
    end
  end

  assign byte_accept = rdy_sync_q & ~rdy_prev_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    led_cnt_d  = led_cnt_q;
    byte_idx_d = byte_idx_q;
    g_d        = g_q;
    r_d        = r_q;
    acc_d      = acc_q;
    to_cnt_d   = to_cnt_q;
    wr_d       = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    cerr_d     = 1'b0;
    terr_d     = 1'b0;

    if (byte_accept) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            acc_d   = 8'h00;
            state_d = ST_ADDR_HI;
          end
        end
        ST_ADDR_HI: begin
          acc_d   = acc_q ^ rx_data;
          addr_d  = ADDRESS_WIDTH'({rx_data, 8'h00});
          state_d = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          acc_d   = acc_q ^ rx_data;
          addr_d  = addr_q | ADDRESS_WIDTH'(rx_data);
          state_d = ST_COUNT;
        end
        ST_COUNT: begin
          acc_d      = acc_q ^ rx_data;
          led_cnt_d  = rx_data;
          byte_idx_d = 2'd0;
          state_d    = (rx_data == 8'h00) ? ST_CHECK : ST_DATA;
        end
        ST_DATA: begin
          acc_d = acc_q ^ rx_data;
          case (byte_idx_q)
            2'd0: begin
              g_d        = rx_data;
              byte_idx_d = 2'd1;
            end
            2'd1: begin
              r_d        = rx_data;
              byte_idx_d = 2'd2;
            end
            default: begin
              wr_d       = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = {g_q, r_q, rx_data};
              addr_d     = addr_q + 1'b1;
              led_cnt_d  = led_cnt_q - 8'd1;
              byte_idx_d = 2'd0;
              if (led_cnt_q == 8'd1) state_d = ST_CHECK;
            end
          endcase
        end
        ST_CHECK: begin
          done_d  = (acc_q == rx_data);
          cerr_d  = (acc_q != rx_data);
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A byte arriving on the expiry cycle wins; otherwise the open packet is abandoned.
      if (to_cnt_q == TIMEOUT_LAST) begin
        terr_d     = 1'b1;
        state_d    = ST_IDLE;
        byte_idx_d = 2'd0;
        to_cnt_d   = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      led_cnt_q  <= 8'h00;
      byte_idx_q <= 2'd0;
      g_q        <= 8'h00;
      r_q        <= 8'h00;
      acc_q      <= 8'h00;
      to_cnt_q   <= '0;
      wr_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 24'h0;
      done_q     <= 1'b0;
      cerr_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      led_cnt_q  <= led_cnt_d;
      byte_idx_q <= byte_idx_d;
      g_q        <= g_d;
      r_q        <= r_d;
      acc_q      <= acc_d;
      to_cnt_q   <= to_cnt_d;
      wr_q       <= wr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      cerr_q     <= cerr_d;
      terr_q     <= terr_d;
    end
  end

  assign perform_write  = wr_q;
  assign write_address  = wr_addr_q;
  assign write_data     = wr_data_q;
  assign frame_done     = done_q;
  assign checksum_error = cerr_q;
  assign timeout_error  = terr_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_packet_parser.sv
// Bench for led_packet_parser: directed scenarios plus random packets, checked
// against a packet-level model that predicts writes and terminating pulses.
module tb_led_packet_parser;

  localparam int AW = 9;
  localparam int TO = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_rdy;
  logic          perform_write;
  logic [AW-1:0] write_address;
  logic [23:0]   write_data;
  logic          frame_done, checksum_error, timeout_error, busy;

  led_packet_parser #(
    .ADDRESS_WIDTH (AW),
    .TIMEOUT_CYCLES(TO),
    .SYNC_BYTE     (8'hAA)
  ) dut (
    .clock_12mhz   (clk),
    .reset         (rst),
    .rx_data       (rx_data),
    .rx_data_ready (rx_rdy),
    .perform_write (perform_write),
    .write_address (write_address),
    .write_data    (write_data),
    .frame_done    (frame_done),
    .checksum_error(checksum_error),
    .timeout_error (timeout_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  a;
    logic [23:0] d;
  } wr_t;

  int         total = 0;
  int         bad   = 0;
  wr_t        exp_wr[$];
  int         exp_ev[$];   // 1 = frame_done, 2 = checksum_error, 3 = timeout_error
  logic [7:0] pkt[$];
  logic [7:0] cols[$];
  wr_t        mon_w;
  logic [2:0] mon_got, mon_want;

  // Reference model: whole packet from address, count, colours and checksum rule.
  task automatic build_pkt(input logic [8:0] addr, input logic [6:0] hi_junk, input int n,
                           input int mode, input bit use_cols);
    logic [7:0] ck, hb, g, r, b, chk;
    wr_t        t;
    pkt.delete();
    hb = {hi_junk, addr[8]};
    pkt.push_back(8'hAA);
    pkt.push_back(hb);
    pkt.push_back(addr[7:0]);
    pkt.push_back(n[7:0]);
    ck = hb ^ addr[7:0] ^ n[7:0];
    for (int i = 0; i < n; i++) begin
      if (use_cols) begin
        g = cols[3*i]; r = cols[3*i+1]; b = cols[3*i+2];
      end else begin
        g = 8'($urandom); r = 8'($urandom); b = 8'($urandom);
      end
      pkt.push_back(g); pkt.push_back(r); pkt.push_back(b);
      ck  = ck ^ g ^ r ^ b;
      t.a = 9'((int'(addr) + i) % 512);
      t.d = {g, r, b};
      exp_wr.push_back(t);
    end
    if (mode == 0)      chk = ck;
    else if (mode == 1) chk = ck ^ (8'h01 << $urandom_range(0, 7));
    else                chk = 8'h00;
    pkt.push_back(chk);
    exp_ev.push_back((chk == ck) ? 1 : 2);
  endtask

  task automatic send_byte(input logic [7:0] bv, input int hi, input int lo);
    @(negedge clk);
    rx_data = bv;
    rx_rdy  = 1'b1;
    repeat (hi) @(negedge clk);
    rx_rdy = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      send_byte(pkt[i], $urandom_range(2, 4), $urandom_range(2, 4));
      if (i == 0) begin
        total++;
        assert (busy === 1'b1) else begin
          bad++; $error("FAIL busy_after_sync got=%b want=1", busy);
        end
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_ev.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    assert (exp_wr.size() == 0 && exp_ev.size() == 0) else begin
      bad++; $error("FAIL %s_pending got wr=%0d ev=%0d want 0 0", tag, exp_wr.size(), exp_ev.size());
    end
    total++;
    assert (busy === 1'b0) else begin
      bad++; $error("FAIL %s_busy got=%b want=0", tag, busy);
    end
  endtask

  // Monitor: every strobe and terminating pulse must match the next model expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (perform_write) begin
        total++;
        assert (exp_wr.size() != 0) else begin
          bad++; $error("FAIL write_unexpected got a=%0d d=%06h want none", write_address, write_data);
        end
        if (exp_wr.size() != 0) begin
          mon_w = exp_wr.pop_front();
          total++;
          assert (write_address === mon_w.a && write_data === mon_w.d) else begin
            bad++; $error("FAIL write got a=%0d d=%06h want a=%0d d=%06h",
                          write_address, write_data, mon_w.a, mon_w.d);
          end
        end
      end
      mon_got = {timeout_error, checksum_error, frame_done};
      if (mon_got != 3'b000) begin
        mon_want = (exp_ev.size() != 0) ? (3'b001 << (exp_ev[0] - 1)) : 3'b000;
        total++;
        assert (mon_got === mon_want) else begin
          bad++; $error("FAIL pulse got {to,ce,fd}=%b want=%b", mon_got, mon_want);
        end
        if (exp_ev.size() != 0) void'(exp_ev.pop_front());
        total++;
        assert (busy === 1'b0) else begin
          bad++; $error("FAIL busy_with_pulse got=%b want=0", busy);
        end
      end
    end
  end

  initial begin
    int cyc;
    rst = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    assert ({perform_write, write_address, write_data, frame_done, checksum_error,
             timeout_error, busy} === '0) else begin
      bad++; $error("FAIL reset_outputs got pw=%b a=%0d d=%06h fd=%b ce=%b te=%b busy=%b want all 0",
                    perform_write, write_address, write_data, frame_done, checksum_error,
                    timeout_error, busy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Good two-LED packet at address 5
    cols = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    build_pkt(9'd5, 7'd0, 2, 0, 1'b1);
    send_range(0, pkt.size() - 1);
    wait_idle("good");
    $display("txn good_packet addr=5 count=2");

    // Wrap from 511 to 0
    build_pkt(9'h1FF, 7'd0, 2, 0, 1'b0);
    send_range(0, pkt.size() - 1);
    wait_idle("wrap");
    $display("txn wrap addr=511 count=2");

    // Same colours, checksum forced to 0x00
    build_pkt(9'd5, 7'd0, 2, 2, 1'b1);
    send_range(0, pkt.size() - 1);
    wait_idle("badck");
    $display("txn bad_checksum addr=5 count=2");

    // Idle garbage, then COUNT = 0
    send_byte(8'h55, 3, 3);
    send_byte(8'h12, 3, 3);
    total++;
    assert (busy === 1'b0) else begin
      bad++; $error("FAIL garbage_busy got=%b want=0", busy);
    end
    build_pkt(9'd3, 7'd0, 0, 0, 1'b0);
    send_range(0, pkt.size() - 1);
    wait_idle("count0");
    $display("txn count0 addr=3");

    // Timeout after a truncated header
    send_byte(8'hAA, 3, 3);
    send_byte(8'h00, 3, 3);
    send_byte(8'h01, 3, 3);
    exp_ev.push_back(3);
    cyc = 0;
    while (exp_ev.size() != 0 && cyc < TO + 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == TO / 2) begin
        total++;
        assert (busy === 1'b1) else begin
          bad++; $error("FAIL timeout_busy_mid got=%b want=1", busy);
        end
      end
    end
    total++;
    assert (cyc >= TO - 12 && cyc <= TO + 2) else begin
      bad++; $error("FAIL timeout_delay got=%0d want=%0d..%0d", cyc, TO - 12, TO + 2);
    end
    wait_idle("timeout");
    build_pkt(9'd100, 7'h2B, 1, 0, 1'b0);
    send_range(0, pkt.size() - 1);
    wait_idle("after_timeout");
    $display("txn timeout cycles=%0d then good packet", cyc);

    // Reset mid-DATA: first LED written, second LED half-received
    build_pkt(9'd16, 7'd0, 3, 0, 1'b0);
    send_range(0, 8);
    repeat (3) @(negedge clk);
    total++;
    assert (exp_wr.size() == 2) else begin
      bad++; $error("FAIL pre_reset_writes got_left=%0d want=2", exp_wr.size());
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    exp_wr.delete();
    exp_ev.delete();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    assert (busy === 1'b0) else begin
      bad++; $error("FAIL reset_mid_busy got=%b want=0", busy);
    end
    build_pkt(9'd40, 7'd0, 2, 0, 1'b0);
    send_range(0, pkt.size() - 1);
    wait_idle("after_reset");
    $display("txn reset_mid_data then good packet addr=40");

    // SYNC level held through reset release must not be accepted
    rst = 1'b1; rx_data = 8'hAA; rx_rdy = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    rx_rdy = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    assert (busy === 1'b0) else begin
      bad++; $error("FAIL held_in_reset got busy=%b want=0", busy);
    end
    $display("txn sync_held_through_reset");

    // SYNC held for 50 cycles counts once
    build_pkt(9'd7, 7'd0, 1, 0, 1'b0);
    send_byte(pkt[0], 50, 3);
    send_range(1, pkt.size() - 1);
    wait_idle("held50");
    $display("txn long_ready addr=7 count=1");

    // Random packets with idle garbage and occasional bad checksum
    for (int k = 0; k < 14; k++) begin
      logic [8:0] ra;
      int         rn, rm, ng;
      ra = 9'($urandom_range(0, 511));
      rn = $urandom_range(0, 6);
      rm = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ng = $urandom_range(0, 2);
      for (int j = 0; j < ng; j++) send_byte(8'($urandom_range(0, 8'hA9)), 2, 2);
      build_pkt(ra, 7'($urandom), rn, rm, 1'b0);
      send_range(0, pkt.size() - 1);
      wait_idle("random");
      $display("txn random k=%0d addr=%0d count=%0d badck=%0d", k, ra, rn, rm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
